// File: rtl/l2_response_receiver.sv
// -----------------------------------------------------------------------------
// l2_response_receiver
//
// The core-side endpoint of the broadcast L2 response bus. It takes every
// packet addressed to CORE_ID and turns it into single-cycle strobes for the
// L1 instruction and data caches. It drops packets addressed to other cores.
// The block also keeps a bitmap of the outstanding request IDs for each cache
// type, and it raises a sticky flag when the request/response protocol is
// broken.
//
// Handshake: l2_response_valid is a valid-only strobe with no ready. The block
// accepts one packet per cycle with no backpressure. Every packet that matches
// CORE_ID is consumed in the cycle it is presented. dcache_req_valid and
// icache_req_valid are also valid-only, and each one marks one issued request
// in that cycle.
//
// Pipeline:
//   stage 1 (N+1) : latch the matching packet, apply tracking clears/sets
//   stage 2 (N+2) : registered decode strobes, wake bitmap, fill address/data
//
// Optional build macro: L2_RSP_PERF_COUNT_EN adds the perf_rsp_count and
// perf_drop_count ports. These are 32-bit wrapping counters.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   l2_response_valid    response packet valid this cycle
//   l2_response          response packet (l2rsp_packet_t)
//   dcache_req_valid/id  data-side request issued to L2, with its ID
//   icache_req_valid/id  instruction-side request issued to L2, with its ID
//   dfill_en, ifill_en   line fill strobes for the data and instruction caches
//   fill_address/data    line address and data for a fill or invalidate
//   store_ack_en/status  store acknowledged, with its status bit
//   dinvalidate_en       data-cache invalidate strobe
//   iinvalidate_en       instruction-cache invalidate strobe
//   flush_ack_en         flush complete strobe
//   wake_bitmap          one-hot thread to wake
//   dcache_pending       outstanding data request IDs
//   icache_pending       outstanding instruction request IDs
//   protocol_error       sticky protocol violation flag
// -----------------------------------------------------------------------------

package l2_response_pkg;
   localparam int CORE_ID_W   = 4;
   localparam int ID_FIELD_W  = 4;
   localparam int LINE_BITS   = 512;
   localparam int LINE_ADDR_W = 26;

   typedef logic [LINE_BITS-1:0]   cache_line_data_t;
   typedef logic [LINE_ADDR_W-1:0] l2_addr_t;

   typedef enum logic [2:0] {
      L2_RSP_LOAD_ACK        = 3'd0,
      L2_RSP_STORE_ACK       = 3'd1,
      L2_RSP_FLUSH_ACK       = 3'd2,
      L2_RSP_DINVALIDATE_ACK = 3'd3,
      L2_RSP_IINVALIDATE_ACK = 3'd4
   } l2rsp_packet_type_t;

   typedef enum logic {
      CT_ICACHE = 1'b0,
      CT_DCACHE = 1'b1
   } cache_type_t;

   typedef struct packed {
      logic                   status;
      logic [CORE_ID_W-1:0]   core;
      logic [ID_FIELD_W-1:0]  id;
      l2rsp_packet_type_t     packet_type;
      cache_type_t            cache_type;
      cache_line_data_t       data;
      l2_addr_t               address;
   } l2rsp_packet_t;
endpackage

module l2_response_receiver
   import l2_response_pkg::*;
#(
   parameter int CORE_ID = 0,
   parameter int NUM_IDS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       l2_response_valid,
   input  l2rsp_packet_t              l2_response,
   input  logic                       dcache_req_valid,
   input  logic [$clog2(NUM_IDS)-1:0] dcache_req_id,
   input  logic                       icache_req_valid,
   input  logic [$clog2(NUM_IDS)-1:0] icache_req_id,
   output logic                       dfill_en,
   output logic                       ifill_en,
   output l2_addr_t                   fill_address,
   output cache_line_data_t           fill_data,
   output logic                       store_ack_en,
   output logic                       store_ack_status,
   output logic                       dinvalidate_en,
   output logic                       iinvalidate_en,
   output logic                       flush_ack_en,
   output logic [NUM_IDS-1:0]         wake_bitmap,
   output logic [NUM_IDS-1:0]         dcache_pending,
   output logic [NUM_IDS-1:0]         icache_pending,
`ifdef L2_RSP_PERF_COUNT_EN
   output logic [31:0]                perf_rsp_count,
   output logic [31:0]                perf_drop_count,
`endif
   output logic                       protocol_error
);
   localparam int ID_W = $clog2(NUM_IDS);
   localparam logic [CORE_ID_W-1:0] MY_CORE = CORE_ID_W'(CORE_ID);

   // Stage-1 packet fields. Only the ID bits this configuration uses are kept.
   logic               s1_valid;
   logic               s1_status;
   logic [ID_W-1:0]    s1_id;
   l2rsp_packet_type_t s1_type;
   cache_type_t        s1_ctype;
   cache_line_data_t   s1_data;
   l2_addr_t           s1_addr;

   logic core_match;
   logic unused_id_bits;

   // The upper ID bits are ignored when NUM_IDS < 16.
   assign unused_id_bits = ^l2_response.id;
   assign core_match     = l2_response_valid && (l2_response.core == MY_CORE);

   // ---------------------------------------------------------------- stage 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_status <= 1'b0;
         s1_id     <= '0;
         s1_type   <= L2_RSP_LOAD_ACK;
         s1_ctype  <= CT_ICACHE;
         s1_data   <= '0;
         s1_addr   <= '0;
      end else begin
         s1_valid <= core_match;
         if (core_match) begin
            s1_status <= l2_response.status;
            s1_id     <= l2_response.id[ID_W-1:0];
            s1_type   <= l2_response.packet_type;
            s1_ctype  <= l2_response.cache_type;
            s1_data   <= l2_response.data;
            s1_addr   <= l2_response.address;
         end
      end
   end

   // ------------------------------------------------------------- tracking
   // Load, store and flush acks retire one outstanding request. Invalidates
   // are broadcast, so they are not tied to any request.
   logic               s1_is_ack;
   logic               s1_wakes;
   logic [NUM_IDS-1:0] s1_id_onehot;
   logic [NUM_IDS-1:0] dcache_clr, icache_clr;
   logic [NUM_IDS-1:0] dcache_set, icache_set;
   logic               ack_miss;
   logic               req_conflict;

   always_comb begin
      s1_is_ack    = (s1_type == L2_RSP_LOAD_ACK) || (s1_type == L2_RSP_STORE_ACK) ||
                     (s1_type == L2_RSP_FLUSH_ACK);
      s1_wakes     = s1_valid && s1_is_ack;
      s1_id_onehot = '0;
      s1_id_onehot[s1_id] = 1'b1;

      dcache_clr = '0;
      icache_clr = '0;
      ack_miss   = 1'b0;
      if (s1_wakes) begin
         if (s1_ctype == CT_DCACHE) begin
            dcache_clr = s1_id_onehot;
            ack_miss   = !dcache_pending[s1_id];
         end else begin
            icache_clr = s1_id_onehot;
            ack_miss   = !icache_pending[s1_id];
         end
      end

      dcache_set = '0;
      icache_set = '0;
      if (dcache_req_valid) dcache_set[dcache_req_id] = 1'b1;
      if (icache_req_valid) icache_set[icache_req_id] = 1'b1;

      // Re-issuing an ID is legal only when its ack retires in the same cycle.
      req_conflict = |(dcache_set & dcache_pending & ~dcache_clr) ||
                     |(icache_set & icache_pending & ~icache_clr);
   end

   // When one ID is cleared and set in the same cycle, the set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcache_pending <= '0;
         icache_pending <= '0;
         protocol_error <= 1'b0;
      end else begin
         dcache_pending <= (dcache_pending & ~dcache_clr) | dcache_set;
         icache_pending <= (icache_pending & ~icache_clr) | icache_set;
         if (ack_miss || req_conflict) protocol_error <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- stage 2
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dfill_en         <= 1'b0;
         ifill_en         <= 1'b0;
         store_ack_en     <= 1'b0;
         store_ack_status <= 1'b0;
         flush_ack_en     <= 1'b0;
         dinvalidate_en   <= 1'b0;
         iinvalidate_en   <= 1'b0;
         wake_bitmap      <= '0;
         fill_address     <= '0;
         fill_data        <= '0;
      end else begin
         dfill_en       <= s1_valid && (s1_type == L2_RSP_LOAD_ACK) && (s1_ctype == CT_DCACHE);
         ifill_en       <= s1_valid && (s1_type == L2_RSP_LOAD_ACK) && (s1_ctype == CT_ICACHE);
         store_ack_en   <= s1_valid && (s1_type == L2_RSP_STORE_ACK);
         flush_ack_en   <= s1_valid && (s1_type == L2_RSP_FLUSH_ACK);
         dinvalidate_en <= s1_valid && (s1_type == L2_RSP_DINVALIDATE_ACK);
         iinvalidate_en <= s1_valid && (s1_type == L2_RSP_IINVALIDATE_ACK);
         wake_bitmap    <= s1_wakes ? s1_id_onehot : '0;
         if (s1_valid) begin
            store_ack_status <= s1_status;
            fill_address     <= s1_addr;
            fill_data        <= s1_data;
         end
      end
   end

`ifdef L2_RSP_PERF_COUNT_EN
   // These counters count in stage 1 and wrap naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_rsp_count  <= '0;
         perf_drop_count <= '0;
      end else begin
         if (core_match)                       perf_rsp_count  <= perf_rsp_count + 32'd1;
         if (l2_response_valid && !core_match) perf_drop_count <= perf_drop_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_response_receiver.sv
module tb_l2_response_receiver;
   import l2_response_pkg::*;

   localparam int NUM_IDS = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             l2_response_valid;
   l2rsp_packet_t    l2_response;
   logic             dcache_req_valid;
   logic [1:0]       dcache_req_id;
   logic             icache_req_valid;
   logic [1:0]       icache_req_id;
   logic             dfill_en, ifill_en;
   l2_addr_t         fill_address;
   cache_line_data_t fill_data;
   logic             store_ack_en, store_ack_status;
   logic             dinvalidate_en, iinvalidate_en, flush_ack_en;
   logic [3:0]       wake_bitmap, dcache_pending, icache_pending;
   logic             protocol_error;
`ifdef L2_RSP_PERF_COUNT_EN
   logic [31:0]      perf_rsp_count, perf_drop_count;
`endif

   int checks = 0;
   int passes = 0;

   cache_line_data_t d1, d2;

   // clock / reset block
   always #5 clk = ~clk;

   l2_response_receiver #(.CORE_ID(0), .NUM_IDS(NUM_IDS)) dut (
      .clk(clk), .reset(reset),
      .l2_response_valid(l2_response_valid), .l2_response(l2_response),
      .dcache_req_valid(dcache_req_valid), .dcache_req_id(dcache_req_id),
      .icache_req_valid(icache_req_valid), .icache_req_id(icache_req_id),
      .dfill_en(dfill_en), .ifill_en(ifill_en),
      .fill_address(fill_address), .fill_data(fill_data),
      .store_ack_en(store_ack_en), .store_ack_status(store_ack_status),
      .dinvalidate_en(dinvalidate_en), .iinvalidate_en(iinvalidate_en),
      .flush_ack_en(flush_ack_en), .wake_bitmap(wake_bitmap),
      .dcache_pending(dcache_pending), .icache_pending(icache_pending),
`ifdef L2_RSP_PERF_COUNT_EN
      .perf_rsp_count(perf_rsp_count), .perf_drop_count(perf_drop_count),
`endif
      .protocol_error(protocol_error)
   );

   // ------------------------------------------------------------ scoreboard
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // --------------------------------------------------------------- drivers
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      l2_response_valid = 1'b0;
      dcache_req_valid  = 1'b0;
      icache_req_valid  = 1'b0;
   endtask

   task automatic pkt(input l2rsp_packet_type_t t, input cache_type_t ct, input logic [3:0] id,
                      input logic [3:0] core, input logic st, input l2_addr_t a,
                      input cache_line_data_t d);
      l2_response_valid       = 1'b1;
      l2_response.packet_type = t;
      l2_response.cache_type  = ct;
      l2_response.id          = id;
      l2_response.core        = core;
      l2_response.status      = st;
      l2_response.address     = a;
      l2_response.data        = d;
   endtask

   // Checks that no decode strobe and no wake bit is active.
   task automatic chk_quiet(input string tag);
      chk({tag, " strobes"}, 64'({dfill_en, ifill_en, store_ack_en, flush_ack_en,
                                  dinvalidate_en, iinvalidate_en}), 64'd0);
      chk({tag, " wake"}, 64'(wake_bitmap), 64'd0);
   endtask

   initial begin
      d1 = {8{64'h0123_4567_89ab_cdef}};
      d2 = {8{64'hfeed_face_cafe_beef}};
      l2_response = '0;
      dcache_req_id = '0;
      icache_req_id = '0;
      idle();
      reset = 1'b1;
      repeat (3) tick();
      chk_quiet("reset");
      chk("reset dpend", 64'(dcache_pending), 64'd0);
      chk("reset ipend", 64'(icache_pending), 64'd0);
      chk("reset perr", 64'(protocol_error), 64'd0);
      chk("reset faddr", 64'(fill_address), 64'd0);
      reset = 1'b0;
      tick();

      // Instruction load: request id 2, LOAD_ACK id 2 at address 0x1000
      icache_req_valid = 1'b1; icache_req_id = 2'd2;
      tick(); idle();
      chk("ireq pend", 64'(icache_pending), 64'h4);
      pkt(L2_RSP_LOAD_ACK, CT_ICACHE, 4'd2, 4'd0, 1'b0, 26'h1000, d1);
      tick(); idle();
      chk("ifill early", 64'(ifill_en), 64'd0);
      tick();
      chk("ifill", 64'(ifill_en), 64'd1);
      chk("ifill dfill", 64'(dfill_en), 64'd0);
      chk("ifill addr", 64'(fill_address), 64'h1000);
      chk("ifill data lo", fill_data[63:0], 64'h0123_4567_89ab_cdef);
      chk("ifill wake", 64'(wake_bitmap), 64'h4);
      chk("ifill ipend", 64'(icache_pending), 64'd0);
      chk("ifill perr", 64'(protocol_error), 64'd0);
      tick();
      chk_quiet("ifill pulse end");

      // Store ack with status 0 on data id 1
      dcache_req_valid = 1'b1; dcache_req_id = 2'd1;
      tick(); idle();
      chk("dreq pend", 64'(dcache_pending), 64'h2);
      pkt(L2_RSP_STORE_ACK, CT_DCACHE, 4'd1, 4'd0, 1'b0, 26'h2040, d2);
      tick(); idle(); tick();
      chk("sack en", 64'(store_ack_en), 64'd1);
      chk("sack status", 64'(store_ack_status), 64'd0);
      chk("sack wake", 64'(wake_bitmap), 64'h2);
      chk("sack dpend", 64'(dcache_pending), 64'd0);
      chk("sack data hi", fill_data[511:448], 64'hfeed_face_cafe_beef);

      // Store-sync success with status 1 on data id 3
      dcache_req_valid = 1'b1; dcache_req_id = 2'd3;
      tick(); idle();
      pkt(L2_RSP_STORE_ACK, CT_DCACHE, 4'd3, 4'd0, 1'b1, 26'h0abc, d1);
      tick(); idle(); tick();
      chk("ssync status", 64'(store_ack_status), 64'd1);
      chk("ssync wake", 64'(wake_bitmap), 64'h8);
      chk("ssync perr", 64'(protocol_error), 64'd0);

      // A packet for core 1 is dropped
      pkt(L2_RSP_LOAD_ACK, CT_DCACHE, 4'd0, 4'd1, 1'b0, 26'h3000, d2);
      tick(); idle(); tick();
      chk_quiet("other core");
      chk("other core dpend", 64'(dcache_pending), 64'd0);
      chk("other core perr", 64'(protocol_error), 64'd0);
`ifdef L2_RSP_PERF_COUNT_EN
      chk("perf drop", 64'(perf_drop_count), 64'd1);
      chk("perf rsp", 64'(perf_rsp_count), 64'd3);
`endif

      // Flush ack on data id 2
      dcache_req_valid = 1'b1; dcache_req_id = 2'd2;
      tick(); idle();
      pkt(L2_RSP_FLUSH_ACK, CT_DCACHE, 4'd2, 4'd0, 1'b0, 26'h0040, d2);
      tick(); idle(); tick();
      chk("flush en", 64'(flush_ack_en), 64'd1);
      chk("flush wake", 64'(wake_bitmap), 64'h4);
      chk("flush dpend", 64'(dcache_pending), 64'd0);

      // A LOAD_ACK with nothing pending is still decoded, and the error is sticky
      pkt(L2_RSP_LOAD_ACK, CT_DCACHE, 4'd3, 4'd0, 1'b0, 26'h0500, d1);
      tick(); idle(); tick();
      chk("orphan dfill", 64'(dfill_en), 64'd1);
      chk("orphan addr", 64'(fill_address), 64'h0500);
      chk("orphan perr", 64'(protocol_error), 64'd1);

      // Back-to-back invalidates, with data id 1 outstanding
      dcache_req_valid = 1'b1; dcache_req_id = 2'd1;
      tick(); idle();
      pkt(L2_RSP_DINVALIDATE_ACK, CT_DCACHE, 4'd1, 4'd0, 1'b0, 26'h0600, d2);
      tick();
      pkt(L2_RSP_IINVALIDATE_ACK, CT_ICACHE, 4'd2, 4'd0, 1'b0, 26'h0700, d1);
      tick(); idle();
      chk("dinv en", 64'(dinvalidate_en), 64'd1);
      chk("dinv iinv", 64'(iinvalidate_en), 64'd0);
      chk("dinv wake", 64'(wake_bitmap), 64'd0);
      chk("dinv addr", 64'(fill_address), 64'h0600);
      tick();
      chk("iinv en", 64'(iinvalidate_en), 64'd1);
      chk("iinv dinv", 64'(dinvalidate_en), 64'd0);
      chk("iinv wake", 64'(wake_bitmap), 64'd0);
      chk("inv dpend", 64'(dcache_pending), 64'h2);
      chk("inv ipend", 64'(icache_pending), 64'd0);
      chk("perr sticky", 64'(protocol_error), 64'd1);

      // Reset clears the sticky error and the tracking
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("rst2 perr", 64'(protocol_error), 64'd0);
      chk("rst2 dpend", 64'(dcache_pending), 64'd0);

      // Re-issuing id 0 in the cycle its ack retires in stage 1 is legal
      dcache_req_valid = 1'b1; dcache_req_id = 2'd0;
      tick(); idle();
      chk("reissue pend", 64'(dcache_pending), 64'h1);
      pkt(L2_RSP_LOAD_ACK, CT_DCACHE, 4'd0, 4'd0, 1'b0, 26'h0800, d2);
      tick(); idle();
      dcache_req_valid = 1'b1; dcache_req_id = 2'd0;
      tick(); idle();
      chk("reissue dfill", 64'(dfill_en), 64'd1);
      chk("reissue wake", 64'(wake_bitmap), 64'h1);
      chk("reissue dpend", 64'(dcache_pending), 64'h1);
      chk("reissue perr", 64'(protocol_error), 64'd0);

      // Requesting id 0 again while it is still pending is an error
      dcache_req_valid = 1'b1; dcache_req_id = 2'd0;
      tick(); idle();
      chk("dup req perr", 64'(protocol_error), 64'd1);

      // A reset pulse while a packet sits in stage 1 drops that packet
      pkt(L2_RSP_LOAD_ACK, CT_DCACHE, 4'd0, 4'd0, 1'b0, 26'h0900, d1);
      tick(); idle();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      chk_quiet("mid reset n+2");
      chk("mid reset perr", 64'(protocol_error), 64'd0);
      chk("mid reset dpend", 64'(dcache_pending), 64'd0);
      tick();
      chk_quiet("mid reset n+3");
`ifdef L2_RSP_PERF_COUNT_EN
      chk("perf rsp reset", 64'(perf_rsp_count), 64'd0);
      chk("perf drop reset", 64'(perf_drop_count), 64'd0);
`endif

      // final report
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
